fir_engine: RTL and testbench
=============================

# fir_engine

Parametrised multi-channel FIR multiply-accumulate engine that generalises the single-purpose fixed-tap filters in the audio equaliser path.
- One engine instance serves any band (LP/B1/B2/HP) by selecting a coefficient bank from a shared external synchronous ROM.
- It processes CH channels in lockstep and produces one saturated output sample per channel for every rising edge of `seq`.
- It sits between the sample circular queues, which supply `smpl_in` indexed by `tap_idx`, and the band volume/summing stage.

## Interface
Parameters:
- DW, 16: sample width, signed, for input and output.
- CW, 16: coefficient width, signed.
- NTAPS, 1021: taps per filter.
- CH, 2: channel count; channel 0 occupies the LSBs of packed buses.
- NBANK, 4: number of coefficient banks.
- SHIFT, 15: right-shift (arithmetic) applied to the accumulator before saturation.
- AW, 12: coefficient ROM address width; must satisfy 2^AW >= NBANK*NTAPS.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- seq  in  1  sequencing level; each rising edge starts a filter pass.
- bank  in  clog2(NBANK)  coefficient bank; sampled on the start edge.
- coef_addr  out  AW  ROM address, equal to bank*NTAPS + tap.
- coef_data  in  CW  ROM read data; 1-cycle registered latency.
- tap_idx  out  clog2(NTAPS)  tap index for upstream sample fetch.
- smpl_in  in  CH*DW  samples for the tap presented one cycle earlier (same latency as the ROM).
- busy  out  1  pass in progress.
- out_vld  out  1  1-cycle pulse; out_data updated.
- out_data  out  CH*DW  filtered samples; held between passes.
- sat  out  CH  per-channel saturation flag for the current out_data; held with out_data.

## Operation
- **Start detection.** `seq` is registered into `seq_ff`. A start is `seq & ~seq_ff` sampled on a clk edge (the *start edge*).
- **State machine:** IDLE -> PRIME -> ACCUM -> OUTPUT -> IDLE.
- **Start edge (from any state):**
  - state <= PRIME, tap counter k <= 0, all CH accumulators <= 0.
  - bank is latched into bank_r.
- **PRIME.** coef_addr = bank_r*NTAPS + 0 and tap_idx = 0. Next state is ACCUM with k=1.
- **ACCUM, cycle j (j = 0..NTAPS-1):**
  - coef_data and smpl_in belong to tap j.
  - Each channel performs acc_c += coef_data * smpl_in[c] as a signed product.
  - While j < NTAPS-1, address outputs present tap j+1.
  - After the cycle with j = NTAPS-1, the next state is OUTPUT.
- **OUTPUT.** Each channel computes r = acc_c >>> SHIFT.
  - If r > 2^(DW-1)-1: out_data_c <= 0x7FFF (for DW=16) and sat_c <= 1.
  - If r < -2^(DW-1): out_data_c <= 0x8000 (for DW=16) and sat_c <= 1.
  - Otherwise out_data_c <= r[DW-1:0] and sat_c <= 0.
  - out_vld <= 1 and state <= IDLE.
- **Accumulator width.** DW+CW+clog2(NTAPS), signed, with no intermediate overflow.
- **Address outputs outside PRIME/ACCUM:** coef_addr and tap_idx hold 0.
- **busy** = 1 in PRIME, ACCUM and OUTPUT; 0 otherwise.
- **Restart while busy.** A start edge during PRIME, ACCUM or OUTPUT aborts the pass with no out_vld. A new pass begins exactly as from IDLE, using the newly sampled bank.
- **bank changes mid-pass** are ignored until the next start edge.
- **seq held high** causes no restart. A new pass requires seq to return low for at least one cycle.

## Timing
- **Reset values:** state=IDLE, seq_ff=0, busy=0, out_vld=0, out_data=0, sat=0, coef_addr=0, tap_idx=0, accumulators=0, bank_r=0.
- **Cycle numbering:** cycle 1 is the cycle after the start edge.
  - PRIME occupies cycle 1.
  - ACCUM occupies cycles 2..NTAPS+1.
  - OUTPUT occupies cycle NTAPS+2.
  - out_vld is high, with new out_data and sat, for cycle NTAPS+3 only.
  - busy is low in cycle NTAPS+3.
- **Latency** from start edge to out_vld is NTAPS+3 cycles. The minimum start-to-start period with no abort is NTAPS+3 cycles.
- **Start on the same edge as the OUTPUT-state edge:** the start wins. The pass is aborted, out_vld stays 0 and out_data is unchanged.
- **Asynchronous reset mid-pass** forces all reset values immediately. out_vld is never generated for the interrupted pass.

## Test plan
- **Impulse response.** NTAPS=8, CH=2, bank 0 coefficients 1..8, SHIFT=0. smpl_in = 1 (ch0) and 2 (ch1) for every tap.
  - Required: out_data = 36 / 72, sat=0, single out_vld in cycle 11.
  - Required: coef_addr sequence 0..7, 0..7 visible in cycles 1..8.
- **Bank select and latch.** NTAPS=8, NBANK=4, bank=2 at the start edge, bank changed to 3 mid-pass.
  - Required: coef_addr runs 16..23 throughout the pass.
- **Saturation and sign.** Default widths, all coefficients 0x7FFF, smpl_in ch0=0x7FFF, ch1=0x8000.
  - Required: out_data ch0 = 0x7FFF with sat[0]=1; ch1 = 0x8000 with sat[1]=1.
  - Repeat with smpl_in = 0 for both channels: out_data = 0, sat = 0.
- **Restart mid-pass.** NTAPS=8, second seq rising edge in cycle 5.
  - Required: no out_vld for the first pass.
  - Required: out_vld exactly 11 cycles after the second start edge, with correct sum.
- **Reset and level handling.**
  - Assert rst_n=0 during ACCUM: all outputs return to reset values at once, no out_vld.
  - Hold seq high for 3*NTAPS cycles: exactly one pass and one out_vld.
- **Default config.** NTAPS=1021, SHIFT=15, random 16-bit coefficients and samples, compared against a bit-exact reference model.
  - Required: out_vld at start edge + 1024 cycles, bit-exact outputs.

Source files
------------

// File: rtl/fir_engine.sv
// Multi-channel FIR multiply-accumulate engine: one pass per rising edge of seq,
// coefficients from a banked external synchronous ROM, saturated per-channel outputs.
module fir_engine #(
    parameter  int DW    = 16,
    parameter  int CW    = 16,
    parameter  int NTAPS = 1021,
    parameter  int CH    = 2,
    parameter  int NBANK = 4,
    parameter  int SHIFT = 15,
    parameter  int AW    = 12,
    localparam int BW    = (NBANK > 1) ? $clog2(NBANK) : 1,
    localparam int TW    = (NTAPS > 1) ? $clog2(NTAPS) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               seq,
    input  logic [BW-1:0]      bank,
    output logic [AW-1:0]      coef_addr,
    input  logic [CW-1:0]      coef_data,
    output logic [TW-1:0]      tap_idx,
    input  logic [CH*DW-1:0]   smpl_in,
    output logic               busy,
    output logic               out_vld,
    output logic [CH*DW-1:0]   out_data,
    output logic [CH-1:0]      sat
);

    localparam int KW   = $clog2(NTAPS + 1);
    localparam int PW   = DW + CW;
    localparam int ACCW = DW + CW + $clog2(NTAPS);
    localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'({1'b0, {(DW-1){1'b1}}});
    localparam logic signed [ACCW-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {S_IDLE, S_PRIME, S_ACCUM, S_OUTPUT} state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic                    r_seq_ff;
    logic                    w_start;
    logic [BW-1:0]           r_bank;
    logic [KW-1:0]           r_k;
    logic signed [ACCW-1:0]  r_acc [CH];
    logic signed [CW-1:0]    w_coef_s;
    logic signed [PW-1:0]    w_prod [CH];
    logic signed [ACCW-1:0]  w_shr [CH];
    logic [DW-1:0]           w_res [CH];
    logic [CH-1:0]           w_sat;
    logic                    w_addr_active;
    logic                    r_out_vld;
    logic [CH*DW-1:0]        r_out_data;
    logic [CH-1:0]           r_sat;

    assign w_start  = seq & ~r_seq_ff;
    assign w_coef_s = signed'(coef_data);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // A start edge overrides whatever the current state would do next.
    always_comb begin
        // NOTE: default assigned first so no path through the case leaves w_next unassigned (no latch).
        w_next = r_state;
        case (r_state)
            S_PRIME:  w_next = S_ACCUM;
            S_ACCUM:  if (r_k == KW'(NTAPS)) w_next = S_OUTPUT;
            S_OUTPUT: w_next = S_IDLE;
            default:  w_next = r_state;
        endcase
        if (w_start) w_next = S_PRIME;
    end

    always_comb begin
        for (int c = 0; c < CH; c++) begin
            w_prod[c] = PW'(w_coef_s) * PW'(signed'(smpl_in[c*DW +: DW]));
            w_shr[c]  = r_acc[c] >>> SHIFT;
            w_sat[c]  = (w_shr[c] > SAT_MAX) || (w_shr[c] < SAT_MIN);
            if (w_shr[c] > SAT_MAX)      w_res[c] = {1'b0, {(DW-1){1'b1}}};
            else if (w_shr[c] < SAT_MIN) w_res[c] = {1'b1, {(DW-1){1'b0}}};
            else                         w_res[c] = w_shr[c][DW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seq_ff   <= 1'b0;
            r_bank     <= '0;
            r_k        <= '0;
            r_out_vld  <= 1'b0;
            r_out_data <= '0;
            r_sat      <= '0;
            // NOTE: the accumulators are a handful of flops, not a RAM, so they take the async reset too.
            for (int c = 0; c < CH; c++) r_acc[c] <= '0;
        end else begin
            // NOTE: non-blocking throughout so every register samples pre-edge values.
            r_seq_ff  <= seq;
            r_out_vld <= 1'b0;
            if (w_start) begin
                r_bank <= bank;
                r_k    <= '0;
                for (int c = 0; c < CH; c++) r_acc[c] <= '0;
            end else begin
                case (r_state)
                    S_PRIME: r_k <= KW'(1);
                    S_ACCUM: begin
                        r_k <= r_k + KW'(1);
                        for (int c = 0; c < CH; c++) r_acc[c] <= r_acc[c] + ACCW'(w_prod[c]);
                    end
                    S_OUTPUT: begin
                        r_out_vld <= 1'b1;
                        r_sat     <= w_sat;
                        for (int c = 0; c < CH; c++) r_out_data[c*DW +: DW] <= w_res[c];
                    end
                    default: ;
                endcase
            end
        end
    end

    // r_k already points one tap ahead in ACCUM; the final ACCUM cycle has no next tap.
    assign w_addr_active = (r_state == S_PRIME) ||
                           ((r_state == S_ACCUM) && (r_k < KW'(NTAPS)));
    assign coef_addr = w_addr_active ? AW'(int'(r_bank) * NTAPS + int'(r_k)) : '0;
    assign tap_idx   = w_addr_active ? TW'(r_k) : '0;

    assign busy     = (r_state != S_IDLE);
    assign out_vld  = r_out_vld;
    assign out_data = r_out_data;
    assign sat      = r_sat;

endmodule

// File: tb/tb_fir_engine.sv
// Scoreboard bench for fir_engine: a small 8-tap instance for directed vectors and
// a default-size instance checked against a bit-exact model.
module tb_fir_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        a_seq, a_busy, a_vld;
    logic [1:0]  a_bank, a_sat;
    logic [4:0]  a_addr;
    logic [15:0] a_coef;
    logic [2:0]  a_tap;
    logic [31:0] a_smpl, a_data;

    logic        b_seq, b_busy, b_vld;
    logic [1:0]  b_bank, b_sat;
    logic [11:0] b_addr;
    logic [15:0] b_coef;
    logic [9:0]  b_tap;
    logic [31:0] b_smpl, b_data;

    fir_engine #(.DW(16), .CW(16), .NTAPS(8), .CH(2), .NBANK(4), .SHIFT(0), .AW(5)) u_a (
        .clk(clk), .rst_n(rst_n), .seq(a_seq), .bank(a_bank), .coef_addr(a_addr),
        .coef_data(a_coef), .tap_idx(a_tap), .smpl_in(a_smpl), .busy(a_busy),
        .out_vld(a_vld), .out_data(a_data), .sat(a_sat)
    );

    fir_engine u_b (
        .clk(clk), .rst_n(rst_n), .seq(b_seq), .bank(b_bank), .coef_addr(b_addr),
        .coef_data(b_coef), .tap_idx(b_tap), .smpl_in(b_smpl), .busy(b_busy),
        .out_vld(b_vld), .out_data(b_data), .sat(b_sat)
    );

    logic signed [15:0] rom_a [0:31];
    logic signed [15:0] smp_a [0:1][0:7];
    logic signed [15:0] rom_b [0:4095];
    logic signed [15:0] smp_b [0:1][0:1020];

    // Synchronous ROMs and sample queues: one-cycle registered latency.
    always @(posedge clk) begin
        a_coef <= rom_a[a_addr];
        a_smpl <= {smp_a[1][a_tap], smp_a[0][a_tap]};
        b_coef <= rom_b[b_addr];
        b_smpl <= {smp_b[1][b_tap], smp_b[0][b_tap]};
    end

    int cnt = 0;
    always @(posedge clk) cnt <= cnt + 1;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  sat;
        int          cyc;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   a_t0, b_t0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitors: pop and compare whenever an instance presents out_vld.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (a_vld === 1'b1) begin
                if (q_a.size() == 0) begin
                    check("a_unexpected_vld", 64'(a_vld), 64'(0));
                end else begin
                    e = q_a.pop_front();
                    check("a_out_data", 64'(a_data), 64'(e.data));
                    check("a_sat", 64'(a_sat), 64'(e.sat));
                    check("a_vld_cycle", 64'(cnt), 64'(e.cyc));
                end
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (b_vld === 1'b1) begin
                if (q_b.size() == 0) begin
                    check("b_unexpected_vld", 64'(b_vld), 64'(0));
                end else begin
                    e = q_b.pop_front();
                    check("b_out_data", 64'(b_data), 64'(e.data));
                    check("b_sat", 64'(b_sat), 64'(e.sat));
                    check("b_vld_cycle", 64'(cnt), 64'(e.cyc));
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, t=%0t", $time);
        $fatal(1);
    end

    task automatic set_smp_a(input logic [15:0] s0, input logic [15:0] s1);
        for (int k = 0; k < 8; k++) begin
            smp_a[0][k] = s0;
            smp_a[1][k] = s1;
        end
    endtask

    // Leaves the bench at #1 into cycle 1 (PRIME) of the new pass.
    task automatic a_start(input logic [1:0] b, input bit hold);
        @(negedge clk);
        a_seq = 1'b0;
        @(negedge clk);
        a_seq  = 1'b1;
        a_bank = b;
        @(posedge clk);
        #1;
        a_t0 = cnt;
        if (!hold) a_seq = 1'b0;
    endtask

    task automatic b_start(input logic [1:0] b);
        @(negedge clk);
        b_seq = 1'b0;
        @(negedge clk);
        b_seq  = 1'b1;
        b_bank = b;
        @(posedge clk);
        #1;
        b_t0  = cnt;
        b_seq = 1'b0;
    endtask

    task automatic push_a(input logic [31:0] d, input logic [1:0] s);
        q_a.push_back('{d, s, a_t0 + 10});
    endtask

    task automatic a_idle();
        for (int i = 0; i < 40 && (a_busy === 1'b1 || q_a.size() != 0); i++) @(posedge clk);
        check("a_idle_timeout", 64'(a_busy), 64'(0));
    endtask

    task automatic b_idle();
        for (int i = 0; i < 1200 && (b_busy === 1'b1 || q_b.size() != 0); i++) @(posedge clk);
        check("b_idle_timeout", 64'(b_busy), 64'(0));
    endtask

    // Reference: full-precision dot product, arithmetic shift, saturate to 16 bits.
    task automatic b_expect(input int bank);
        logic [31:0] d;
        logic [1:0]  s;
        longint      acc, r;
        for (int c = 0; c < 2; c++) begin
            acc = 0;
            for (int k = 0; k < 1021; k++)
                acc += longint'(rom_b[bank*1021 + k]) * longint'(smp_b[c][k]);
            r = acc >>> 15;
            if (r > 32767)       begin d[c*16 +: 16] = 16'h7FFF; s[c] = 1'b1; end
            else if (r < -32768) begin d[c*16 +: 16] = 16'h8000; s[c] = 1'b1; end
            else                 begin d[c*16 +: 16] = r[15:0];  s[c] = 1'b0; end
        end
        q_b.push_back('{d, s, b_t0 + 1023});
    endtask

    initial begin
        rst_n  = 1'b0;
        a_seq  = 1'b0;
        a_bank = 2'd0;
        b_seq  = 1'b0;
        b_bank = 2'd0;
        for (int i = 0; i < 8; i++) begin
            rom_a[i]      = 16'(i + 1);
            rom_a[8 + i]  = 16'h7FFF;
            rom_a[16 + i] = 16'd10;
            rom_a[24 + i] = 16'hFFFF;
        end
        for (int i = 0; i < 4096; i++) rom_b[i] = 16'($urandom);
        for (int k = 0; k < 1021; k++) begin
            smp_b[0][k] = 16'($urandom);
            smp_b[1][k] = 16'($urandom);
        end
        set_smp_a(16'd0, 16'd0);

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(a_busy), 64'(0));
        check("rst_vld", 64'(a_vld), 64'(0));
        check("rst_data", 64'(a_data), 64'(0));
        check("rst_sat", 64'(a_sat), 64'(0));
        check("rst_addr", 64'(a_addr), 64'(0));
        check("rst_tap", 64'(a_tap), 64'(0));
        check("rst_b_addr", 64'(b_addr), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Impulse: coefficients 1..8, samples 1/2 -> 36/72.
        set_smp_a(16'd1, 16'd2);
        a_start(2'd0, 1'b0);
        push_a({16'd72, 16'd36}, 2'b00);
        for (int n = 1; n <= 11; n++) begin
            if (n <= 8) begin
                check("imp_addr", 64'(a_addr), 64'(n - 1));
                check("imp_tap", 64'(a_tap), 64'(n - 1));
            end
            if (n == 1 || n == 10) check("imp_busy_hi", 64'(a_busy), 64'(1));
            if (n == 11)           check("imp_busy_lo", 64'(a_busy), 64'(0));
            if (n < 11) begin
                @(posedge clk);
                #1;
            end
        end
        a_idle();

        // Bank latch: bank 2 (coef 10), switched to 3 mid-pass -> 80/160.
        a_start(2'd2, 1'b0);
        push_a({16'd160, 16'd80}, 2'b00);
        for (int n = 1; n <= 8; n++) begin
            check("bank_addr", 64'(a_addr), 64'(16 + n - 1));
            if (n == 3) a_bank = 2'd3;
            @(posedge clk);
            #1;
        end
        a_idle();

        // Saturation both directions, then all-zero samples.
        set_smp_a(16'h7FFF, 16'h8000);
        a_start(2'd1, 1'b0);
        push_a({16'h8000, 16'h7FFF}, 2'b11);
        a_idle();
        set_smp_a(16'd0, 16'd0);
        a_start(2'd1, 1'b0);
        push_a(32'd0, 2'b00);
        a_idle();

        // Restart in cycle 5: second pass bank 2, samples 3/-1 -> 240/-80.
        set_smp_a(16'd1, 16'd2);
        a_start(2'd0, 1'b0);
        repeat (2) @(posedge clk);
        set_smp_a(16'd3, 16'hFFFF);
        a_start(2'd2, 1'b0);
        push_a({16'hFFB0, 16'd240}, 2'b00);
        a_idle();

        // Start coinciding with the OUTPUT edge: pass aborted, out_data keeps 240/-80.
        set_smp_a(16'd1, 16'd2);
        a_start(2'd0, 1'b0);
        repeat (8) @(posedge clk);
        a_start(2'd0, 1'b0);
        check("coll_vld", 64'(a_vld), 64'(0));
        check("coll_data", 64'(a_data), 64'({16'hFFB0, 16'd240}));
        check("coll_busy", 64'(a_busy), 64'(1));
        push_a({16'd72, 16'd36}, 2'b00);
        a_idle();

        // Asynchronous reset in ACCUM.
        a_start(2'd0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mrst_busy", 64'(a_busy), 64'(0));
        check("mrst_vld", 64'(a_vld), 64'(0));
        check("mrst_data", 64'(a_data), 64'(0));
        check("mrst_sat", 64'(a_sat), 64'(0));
        check("mrst_addr", 64'(a_addr), 64'(0));
        check("mrst_tap", 64'(a_tap), 64'(0));
        a_seq = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(posedge clk);

        // seq held high for 24 cycles: one pass, samples 2/-3 -> 72/-108.
        set_smp_a(16'd2, 16'hFFFD);
        a_start(2'd0, 1'b1);
        push_a({16'hFF94, 16'd72}, 2'b00);
        repeat (24) @(posedge clk);
        a_seq = 1'b0;
        a_idle();
        repeat (12) @(posedge clk);

        // Default configuration against the reference model.
        b_start(2'd1);
        check("b_addr_prime", 64'(b_addr), 64'(1021));
        b_expect(1);
        b_idle();
        for (int k = 0; k < 1021; k++) begin
            smp_b[0][k] = 16'($urandom_range(0, 2046)) - 16'd1023;
            smp_b[1][k] = 16'($urandom_range(0, 2046)) - 16'd1023;
        end
        b_start(2'd3);
        check("b_addr_prime3", 64'(b_addr), 64'(3063));
        b_expect(3);
        b_idle();

        for (int i = 0; i < 200 && (q_a.size() + q_b.size()) != 0; i++) @(posedge clk);
        check("scoreboard_drain", 64'(q_a.size() + q_b.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
